// File: rtl/axis_bram_adapter_v2_s00_axis.sv
// AXI4-Stream slave that captures one frame per ENABLE into a BRAM write port.
// Ports:
//   S_AXIS_ACLK / S_AXIS_ARESETN   clock, async active-low reset
//   S_AXIS_T*                       stream input (TVALID/TREADY/TDATA/TSTRB/TLAST)
//   ENABLE, FRAME_ACK               arm capture / release a completed frame
//   BRAM_READY                      BRAM side can take a write this cycle
//   BRAM_EN/WE/ADDR/DIN             registered BRAM write port (1-cycle latency)
//   FRAME_DONE, FRAME_LEN, OVERFLOW frame status; BUSY = not idle
module axis_bram_adapter_v2_s00_axis #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_BRAM_ADDR_WIDTH    = 10,
  parameter int unsigned C_MAX_WORDS          = 1024,
  parameter int unsigned C_WRAP_MODE          = 0
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                ENABLE,
  input  logic                                FRAME_ACK,
  input  logic                                BRAM_READY,
  output logic                                BRAM_EN,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   BRAM_WE,
  output logic [C_BRAM_ADDR_WIDTH-1:0]        BRAM_ADDR,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     BRAM_DIN,
  output logic                                FRAME_DONE,
  output logic [C_BRAM_ADDR_WIDTH:0]          FRAME_LEN,
  output logic                                OVERFLOW,
  output logic                                BUSY
);

  localparam int unsigned DATA_W = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned ADDR_W = C_BRAM_ADDR_WIDTH;
  localparam int unsigned LEN_W  = C_BRAM_ADDR_WIDTH + 1;

  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(C_MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(C_MAX_WORDS - 1);
  localparam bit                WRAP      = (C_WRAP_MODE != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                bram_en_q, bram_en_d;
  logic [STRB_W-1:0]   bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_din_q, bram_din_d;

  logic                tready_c;
  logic                accept_c;
  logic                last_word_c;
  logic                full_c;

  // Ready depends on the live BRAM_READY so a stalled BRAM never loses a beat.
  assign tready_c    = ((state_q == RECV) && BRAM_READY) || (state_q == DRAIN);
  assign accept_c    = S_AXIS_TVALID && tready_c;
  // Beat being accepted is word C_MAX_WORDS of the frame.
  assign last_word_c = (len_q == (LEN_MAX - LEN_W'(1)));
  // Buffer already holds C_MAX_WORDS words; any further RECV beat is excess.
  assign full_c      = (len_q == LEN_MAX);

  // State register and datapath flops.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  // Next-state and write-port logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    bram_en_d   = 1'b0;
    bram_we_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    unique case (state_q)
      IDLE: begin
        if (ENABLE) begin
          state_d = RECV;
          idx_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      RECV: begin
        if (accept_c) begin
          bram_en_d   = 1'b1;
          bram_we_d   = S_AXIS_TSTRB;
          bram_addr_d = idx_q;
          bram_din_d  = S_AXIS_TDATA;
          // Index wraps at the buffer depth, which need not be a power of two.
          idx_d       = (idx_q == ADDR_LAST) ? '0 : idx_q + ADDR_W'(1);
          if (full_c) begin
            ovf_d = 1'b1;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
          if (S_AXIS_TLAST) begin
            state_d = DONE;
          end else if (!WRAP && last_word_c) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Excess beats are swallowed so the upstream frame can complete.
        if (accept_c) begin
          ovf_d = 1'b1;
          if (S_AXIS_TLAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (FRAME_ACK) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign S_AXIS_TREADY = tready_c;
  assign BRAM_EN       = bram_en_q;
  assign BRAM_WE       = bram_we_q;
  assign BRAM_ADDR     = bram_addr_q;
  assign BRAM_DIN      = bram_din_q;
  assign FRAME_DONE    = (state_q == DONE);
  assign FRAME_LEN     = len_q;
  assign OVERFLOW      = ovf_q;
  assign BUSY          = (state_q != IDLE);

endmodule
